mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store unit. Sits directly downstream of the EX/MEM pipeline register.
//  Turns its READ/WRITE/ALU_RESULT/DATA2 outputs into aligned word requests on the data-memory
//  bus, formats load data, and raises BUSYWAIT to freeze the pipeline while an access is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max REQ cycles before ACCESS_FAULT; 0 = timeout disabled
// PORTS
//  CLK            in   1   clock, all state on posedge
//  RESET          in   1   synchronous, active-high reset
//  READ           in   3   000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110/111 = none
//  WRITE          in   2   00 none, 01 SB, 10 SH, 11 SW
//  ADDR           in   32  byte address (EX/MEM ALU result)
//  STORE_DATA     in   32  store source (EX/MEM DATA2)
//  HOLD           in   1   pipeline frozen by another stall source
//  MEM_READ       out  1   memory read request
//  MEM_WRITE      out  1   memory write request
//  MEM_ADDR       out  32  {ADDR[31:2],2'b00}
//  MEM_WRITEDATA  out  32  lane-replicated store data
//  MEM_BYTEEN     out  4   byte-lane enables (bit k = byte k, little-endian)
//  MEM_READDATA   in   32  read word, valid when MEM_BUSYWAIT=0 during a read
//  MEM_BUSYWAIT   in   1   memory not ready
//  LOAD_DATA      out  32  registered, formatted load result
//  BUSYWAIT       out  1   stall request to all pipeline registers and PC
//  MISALIGNED     out  1   registered: LH/LHU/SH with ADDR[0]=1, or LW/SW with ADDR[1:0]!=0
//  ACCESS_FAULT   out  1   registered: timeout expired
// BEHAVIOUR
//  Reset (posedge with RESET=1): state IDLE, MEM_READ=MEM_WRITE=0, MEM_BYTEEN=0, LOAD_DATA=0,
//   MISALIGNED=0, ACCESS_FAULT=0, timeout counter 0. BUSYWAIT=0 while RESET=1.
//  Reset mid-operation drops the request at that edge. No completion and no LOAD_DATA update.
//  Access valid = (READ in 001..101 or WRITE!=00) and aligned. If both READ and WRITE are set, the write wins.
//  FSM IDLE -> REQ -> DONE -> IDLE:
//   IDLE: valid access -> REQ. BUSYWAIT is asserted combinationally in this same cycle.
//         Misaligned access -> MISALIGNED=1 for one cycle. No bus request, no stall, stay IDLE.
//   REQ: MEM_READ/MEM_WRITE/MEM_ADDR/MEM_WRITEDATA/MEM_BYTEEN are registered and held stable. BUSYWAIT=1.
//        Completion = MEM_BUSYWAIT=0 at a posedge. On completion, a read captures the formatted word
//        into LOAD_DATA; requests drop to 0; go to DONE.
//        Timeout: counter counts REQ cycles. If it reaches TIMEOUT_CYCLES (when nonzero),
//        ACCESS_FAULT=1 for one cycle, requests drop, go to DONE. LOAD_DATA is unchanged.
//   DONE: BUSYWAIT=0, so the EX/MEM register advances at the next edge. Stay in DONE while HOLD=1
//        so the same instruction is never re-issued. With HOLD=0, go to IDLE.
//  Latency: with a zero-wait memory, 2-cycle stall (REQ entry + completion); each extra MEM_BUSYWAIT cycle adds 1.
//  Store lanes, k=ADDR[1:0]:
//   SB: BYTEEN=1<<k, WRITEDATA={4{STORE_DATA[7:0]}}
//   SH: BYTEEN=ADDR[1]?1100:0011, WRITEDATA={2{STORE_DATA[15:0]}}
//   SW: BYTEEN=1111
//  Reads: BYTEEN=1111.
//  Load format: byte = READDATA[8k+:8], half = READDATA[16*ADDR[1]+:16].
//   LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
// TESTING
//  1 SB ADDR=0x103 STORE_DATA=0x000000AB -> MEM_BYTEEN=1000, MEM_WRITEDATA=0xABABABAB, MEM_ADDR=0x100.
//  2 LB ADDR=0x102, READDATA=0x00800000 -> LOAD_DATA=0xFFFFFF80.
//    LBU same -> LOAD_DATA=0x00000080.
//    LHU ADDR=0x102, READDATA=0x8001_0000 -> LOAD_DATA=0x00008001.
//  3 LW ADDR=0x101 -> MISALIGNED=1 for 1 cycle, MEM_READ never 1, BUSYWAIT stays 0.
//  4 LW, MEM_BUSYWAIT high 3 cycles after request -> BUSYWAIT high exactly 5 cycles; LOAD_DATA=READDATA.
//  5 TIMEOUT_CYCLES=4, MEM_BUSYWAIT stuck 1 -> ACCESS_FAULT pulses after 4 REQ cycles; BUSYWAIT releases.
//  6 RESET=1 during REQ -> next edge MEM_READ=0, BUSYWAIT=0, LOAD_DATA=0.
//    HOLD=1 in DONE for 3 cycles -> no second request issued.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : MEM-stage load/store unit (aligned word bus, load format, stall)
// Revision 1.0
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  READ,
  input  logic [1:0]  WRITE,
  input  logic [31:0] ADDR,
  input  logic [31:0] STORE_DATA,
  input  logic        HOLD,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WRITEDATA,
  output logic [3:0]  MEM_BYTEEN,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT,
  output logic [31:0] LOAD_DATA,
  output logic        BUSYWAIT,
  output logic        MISALIGNED,
  output logic        ACCESS_FAULT
);

  localparam int            c_cnt_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_tmo_last =
    c_cnt_w'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [2:0] c_none = 3'b000;
  localparam logic [2:0] c_lb   = 3'b001;
  localparam logic [2:0] c_lh   = 3'b010;
  localparam logic [2:0] c_lw   = 3'b011;
  localparam logic [2:0] c_lbu  = 3'b100;
  localparam logic [2:0] c_lhu  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_mem_read;
  logic                 r_mem_write;
  logic [31:0]          r_mem_addr;
  logic [31:0]          r_mem_wdata;
  logic [3:0]           r_mem_byteen;
  logic [31:0]          r_load_data;
  logic                 r_misaligned;
  logic                 r_fault;
  logic [2:0]           r_rd_op;
  logic [1:0]           r_lane;
  logic [c_cnt_w-1:0]   r_cnt;

  logic                 w_is_wr;
  logic                 w_is_rd;
  logic                 w_mis;
  logic                 w_valid;
  logic [2:0]           w_rd_op;
  logic [3:0]           w_be;
  logic [31:0]          w_wdata;
  logic                 w_done_ok;
  logic                 w_timeout;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_fmt;

  // Request decode; a simultaneous write suppresses the read.
  always_comb begin
    w_is_wr = (WRITE != 2'b00);
    w_is_rd = (READ >= c_lb) && (READ <= c_lhu);
    w_rd_op = (!w_is_wr && w_is_rd) ? READ : c_none;
    w_mis   = 1'b0;
    w_be    = 4'b1111;
    w_wdata = 32'd0;
    if (w_is_wr) begin
      case (WRITE)
        2'b01: begin
          w_be    = 4'b0001 << ADDR[1:0];
          w_wdata = {4{STORE_DATA[7:0]}};
        end
        2'b10: begin
          w_mis   = ADDR[0];
          w_be    = ADDR[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{STORE_DATA[15:0]}};
        end
        default: begin
          w_mis   = (ADDR[1:0] != 2'b00);
          w_wdata = STORE_DATA;
        end
      endcase
    end else if (w_is_rd) begin
      case (READ)
        c_lh, c_lhu: w_mis = ADDR[0];
        c_lw:        w_mis = (ADDR[1:0] != 2'b00);
        default:     w_mis = 1'b0;
      endcase
    end
    w_valid = (w_is_wr || w_is_rd) && !w_mis;
  end

  always_comb begin
    w_byte = MEM_READDATA[{r_lane, 3'b000} +: 8];
    w_half = r_lane[1] ? MEM_READDATA[31:16] : MEM_READDATA[15:0];
    case (r_rd_op)
      c_lb:    w_fmt = {{24{w_byte[7]}}, w_byte};
      c_lh:    w_fmt = {{16{w_half[15]}}, w_half};
      c_lbu:   w_fmt = {24'd0, w_byte};
      c_lhu:   w_fmt = {16'd0, w_half};
      default: w_fmt = MEM_READDATA;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_done_ok = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: if (w_valid) w_next = S_REQ;
      S_REQ: begin
        if (!MEM_BUSYWAIT) begin
          w_done_ok = 1'b1;
          w_next    = S_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == c_tmo_last)) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      // Holding here keeps a frozen instruction from being issued twice.
      S_DONE: if (!HOLD) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_byteen <= 4'd0;
      r_load_data  <= 32'd0;
      r_misaligned <= 1'b0;
      r_fault      <= 1'b0;
      r_rd_op      <= c_none;
      r_lane       <= 2'd0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_next;
      r_misaligned <= (r_state == S_IDLE) && w_mis;
      r_fault      <= w_timeout;
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_mem_read   <= (w_rd_op != c_none);
            r_mem_write  <= w_is_wr;
            r_mem_addr   <= {ADDR[31:2], 2'b00};
            r_mem_wdata  <= w_wdata;
            r_mem_byteen <= w_be;
            r_rd_op      <= w_rd_op;
            r_lane       <= ADDR[1:0];
            r_cnt        <= '0;
          end
        end
        S_REQ: begin
          if (w_done_ok || w_timeout) begin
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_byteen <= 4'd0;
            r_cnt        <= '0;
            if (w_done_ok && r_mem_read) r_load_data <= w_fmt;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSYWAIT      = !RESET && (((r_state == S_IDLE) && w_valid) || (r_state == S_REQ));
  assign MEM_READ      = r_mem_read;
  assign MEM_WRITE     = r_mem_write;
  assign MEM_ADDR      = r_mem_addr;
  assign MEM_WRITEDATA = r_mem_wdata;
  assign MEM_BYTEEN    = r_mem_byteen;
  assign LOAD_DATA     = r_load_data;
  assign MISALIGNED    = r_misaligned;
  assign ACCESS_FAULT  = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_access_unit : scoreboard bench for the MEM-stage load/store unit
// Revision 1.0
// ============================================================================
module tb_mem_access_unit;

  logic        CLK;
  logic        RESET;
  logic [2:0]  READ;
  logic [1:0]  WRITE;
  logic [31:0] ADDR;
  logic [31:0] STORE_DATA;
  logic        HOLD;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WRITEDATA;
  logic [3:0]  MEM_BYTEEN;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
  logic [31:0] LOAD_DATA;
  logic        BUSYWAIT;
  logic        MISALIGNED;
  logic        ACCESS_FAULT;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDR(ADDR),
    .STORE_DATA(STORE_DATA), .HOLD(HOLD), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDR(MEM_ADDR), .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_BYTEEN(MEM_BYTEEN),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT), .LOAD_DATA(LOAD_DATA),
    .BUSYWAIT(BUSYWAIT), .MISALIGNED(MISALIGNED), .ACCESS_FAULT(ACCESS_FAULT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef enum int {EV_RST, EV_REQ, EV_END, EV_MIS} ev_t;
  typedef struct {
    ev_t         kind;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] load;
    logic        fault;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic pop_expect(input ev_t k, input string name, output exp_t e, output bit ok);
    n_cmp++;
    ok = 1'b0;
    e  = '{kind: EV_RST, rd: 1'b0, wr: 1'b0, addr: 32'd0, be: 4'd0, wdata: 32'd0,
           stall: 0, load: 32'd0, fault: 1'b0};
    if (q.size() == 0 || q[0].kind != k) begin
      n_err++;
      $display("FAIL %s: actual unexpected event required %0s", name,
               (q.size() == 0) ? "none" : "other event");
    end else begin
      e  = q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic push_rst();
    exp_t e;
    e = '{kind: EV_RST, rd: 1'b0, wr: 1'b0, addr: 32'd0, be: 4'd0, wdata: 32'd0,
          stall: 0, load: 32'd0, fault: 1'b0};
    q.push_back(e);
  endtask

  task automatic push_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    e = '{kind: EV_REQ, rd: rd, wr: wr, addr: a, be: be, wdata: wd,
          stall: 0, load: 32'd0, fault: 1'b0};
    q.push_back(e);
  endtask

  task automatic push_end(input int stall, input logic [31:0] ld, input logic fault);
    exp_t e;
    e = '{kind: EV_END, rd: 1'b0, wr: 1'b0, addr: 32'd0, be: 4'd0, wdata: 32'd0,
          stall: stall, load: ld, fault: fault};
    q.push_back(e);
  endtask

  task automatic push_mis();
    exp_t e;
    e = '{kind: EV_MIS, rd: 1'b0, wr: 1'b0, addr: 32'd0, be: 4'd0, wdata: 32'd0,
          stall: 0, load: 32'd0, fault: 1'b0};
    q.push_back(e);
  endtask

  // Monitor: turns DUT activity into events and checks them against the queue.
  initial begin
    exp_t e;
    bit   ok;
    bit   end_seen;
    logic prev_req;
    logic prev_busy;
    int   stall_cnt;
    prev_req  = 1'b0;
    prev_busy = 1'b0;
    stall_cnt = 0;
    forever begin
      @(negedge CLK);
      end_seen = 1'b0;
      if (RESET) begin
        if (q.size() > 0 && q[0].kind == EV_RST) begin
          e = q.pop_front();
          chk("rst_mem_read",  {31'd0, MEM_READ},     32'd0);
          chk("rst_mem_write", {31'd0, MEM_WRITE},    32'd0);
          chk("rst_byteen",    {28'd0, MEM_BYTEEN},   32'd0);
          chk("rst_busywait",  {31'd0, BUSYWAIT},     32'd0);
          chk("rst_load_data", LOAD_DATA,             e.load);
          chk("rst_misalign",  {31'd0, MISALIGNED},   32'd0);
          chk("rst_fault",     {31'd0, ACCESS_FAULT}, 32'd0);
        end
        prev_req  = 1'b0;
        prev_busy = 1'b0;
        stall_cnt = 0;
      end else begin
        if ((MEM_READ || MEM_WRITE) && !prev_req) begin
          pop_expect(EV_REQ, "req_event", e, ok);
          if (ok) begin
            chk("req_read",   {31'd0, MEM_READ},   {31'd0, e.rd});
            chk("req_write",  {31'd0, MEM_WRITE},  {31'd0, e.wr});
            chk("req_addr",   MEM_ADDR,            e.addr);
            chk("req_byteen", {28'd0, MEM_BYTEEN}, {28'd0, e.be});
            chk("req_stall",  {31'd0, BUSYWAIT},   32'd1);
            if (e.wr) chk("req_wdata", MEM_WRITEDATA, e.wdata);
          end
        end
        if (BUSYWAIT) begin
          stall_cnt++;
        end else if (prev_busy) begin
          end_seen = 1'b1;
          pop_expect(EV_END, "end_event", e, ok);
          if (ok) begin
            chk("stall_cycles", 32'(stall_cnt),        32'(e.stall));
            chk("load_data",    LOAD_DATA,             e.load);
            chk("access_fault", {31'd0, ACCESS_FAULT}, {31'd0, e.fault});
            chk("req_dropped",  {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
          end
          stall_cnt = 0;
        end
        if (ACCESS_FAULT && !end_seen) chk("stray_fault", 32'd1, 32'd0);
        if (MISALIGNED) begin
          pop_expect(EV_MIS, "misaligned_event", e, ok);
          if (ok) chk("mis_no_request", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
        end
        prev_req  = MEM_READ || MEM_WRITE;
        prev_busy = BUSYWAIT;
      end
    end
  end

  task automatic access(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdat,
                        input int busy, input int hold);
    int c;
    bit done;
    @(posedge CLK); #1;
    READ = rd; WRITE = wr; ADDR = a; STORE_DATA = sd;
    MEM_BUSYWAIT = 1'b1; MEM_READDATA = 32'hDEADBEEF;
    c = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      if (!BUSYWAIT) begin
        done = 1'b1;
      end else begin
        @(posedge CLK); #1;
        c++;
        MEM_BUSYWAIT = (c <= busy);
        MEM_READDATA = (c <= busy) ? 32'hDEADBEEF : rdat;
      end
    end
    if (!done) chk("access_timeout", 32'd1, 32'd0);
    MEM_BUSYWAIT = 1'b0;
    HOLD = (hold > 0);
    repeat (hold) @(negedge CLK);
    HOLD = 1'b0;
    @(posedge CLK); #1;
    READ = 3'b000; WRITE = 2'b00;
  endtask

  task automatic misaligned(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a);
    push_mis();
    @(posedge CLK); #1;
    READ = rd; WRITE = wr; ADDR = a;
    @(posedge CLK); #1;
    READ = 3'b000; WRITE = 2'b00;
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    RESET = 1'b1; READ = 3'b000; WRITE = 2'b00; ADDR = 32'd0; STORE_DATA = 32'd0;
    HOLD = 1'b0; MEM_READDATA = 32'd0; MEM_BUSYWAIT = 1'b0;
    repeat (3) @(posedge CLK);
    #1 push_rst();
    @(posedge CLK); #1 RESET = 1'b0;

    push_req(1'b0, 1'b1, 32'h100, 4'b1000, 32'hABABABAB);
    push_end(2, 32'h0, 1'b0);
    access(3'b000, 2'b01, 32'h103, 32'h000000AB, 32'h0, 0, 0);

    push_req(1'b1, 1'b0, 32'h100, 4'b1111, 32'h0);
    push_end(2, 32'hFFFFFF80, 1'b0);
    access(3'b001, 2'b00, 32'h102, 32'h0, 32'h00800000, 0, 0);

    push_req(1'b1, 1'b0, 32'h100, 4'b1111, 32'h0);
    push_end(2, 32'h00000080, 1'b0);
    access(3'b100, 2'b00, 32'h102, 32'h0, 32'h00800000, 0, 0);

    push_req(1'b1, 1'b0, 32'h100, 4'b1111, 32'h0);
    push_end(2, 32'h00008001, 1'b0);
    access(3'b101, 2'b00, 32'h102, 32'h0, 32'h80010000, 0, 0);

    push_req(1'b1, 1'b0, 32'h100, 4'b1111, 32'h0);
    push_end(2, 32'hFFFF8001, 1'b0);
    access(3'b010, 2'b00, 32'h100, 32'h0, 32'h00008001, 0, 0);

    push_req(1'b0, 1'b1, 32'h100, 4'b1100, 32'h56785678);
    push_end(2, 32'hFFFF8001, 1'b0);
    access(3'b000, 2'b10, 32'h102, 32'h12345678, 32'h0, 0, 0);

    // Load and store together: the store is the one issued.
    push_req(1'b0, 1'b1, 32'h204, 4'b1111, 32'hCAFEF00D);
    push_end(2, 32'hFFFF8001, 1'b0);
    access(3'b011, 2'b11, 32'h204, 32'hCAFEF00D, 32'h11111111, 0, 0);

    misaligned(3'b011, 2'b00, 32'h101);
    misaligned(3'b000, 2'b10, 32'h101);

    push_req(1'b1, 1'b0, 32'h200, 4'b1111, 32'h0);
    push_end(5, 32'h13579BDF, 1'b0);
    access(3'b011, 2'b00, 32'h200, 32'h0, 32'h13579BDF, 3, 0);

    push_req(1'b1, 1'b0, 32'h300, 4'b1111, 32'h0);
    push_end(5, 32'h13579BDF, 1'b1);
    access(3'b011, 2'b00, 32'h300, 32'h0, 32'h2468ACE0, 100, 0);

    push_req(1'b1, 1'b0, 32'h000, 4'b1111, 32'h0);
    push_end(2, 32'h0000007F, 1'b0);
    access(3'b001, 2'b00, 32'h001, 32'h0, 32'h00007F00, 0, 3);
    repeat (3) @(posedge CLK);

    // Reset while a request is outstanding.
    push_req(1'b1, 1'b0, 32'h400, 4'b1111, 32'h0);
    @(posedge CLK); #1;
    READ = 3'b011; ADDR = 32'h400; MEM_BUSYWAIT = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    push_rst();
    @(posedge CLK); #1;
    RESET = 1'b0; READ = 3'b000; MEM_BUSYWAIT = 1'b0;
    repeat (6) @(posedge CLK);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
